fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core, directly upstream of decode and the hazard unit.
- Owns PCF and issues word fetches to instruction memory over a req/ready handshake.
- Consumes StallF/StallD from the hazard unit and applies branch/jump redirects resolved in decode.
- Delivers InstrD/PCPlus4D/ValidD to decode and absorbs memory wait states; no branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 00.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
StallF  in  1  hazard unit: hold PCF
StallD  in  1  hazard unit: hold IF/ID register
PCSrcD  in  1  branch taken in decode
PCBranchD  in  32  branch target
JumpD  in  1  jump/jr resolved in decode
PCJumpD  in  32  jump target
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address, [1:0]=00
imem_ready  in  1  rdata valid this cycle, completes request
imem_rdata  in  32  instruction word
InstrD  out  32  instruction to decode (0 = nop bubble)
PCPlus4D  out  32  PC+4 of InstrD
ValidD  out  1  InstrD is a real instruction
FetchWait  out  1  request outstanding and not ready this cycle

Behaviour:
- Reset: PCF=RESET_PC, state=FETCH, imem_req=0 while rst=1, InstrD=0, PCPlus4D=0, ValidD=0, pend target=0, buffer cleared. First request (addr RESET_PC) in first cycle after rst falls.
- Reset mid-transaction: outstanding response abandoned, no D write; memory must tolerate a dropped request.
- Redirect: redir = (PCSrcD|JumpD) & ~StallD. Target = PCJumpD if JumpD, else PCBranchD (jump wins if both). Target[1:0] forced to 00. Not honoured while StallD=1.
- imem_addr is held constant while imem_req=1 and imem_ready=0.
- D-register update occurs only when StallD=0; with StallD=1, InstrD/PCPlus4D/ValidD hold.
- Bubble written to D = InstrD 0, ValidD 0, PCPlus4D unchanged.
- PC+4 wraps mod 2^32.
- FetchWait = imem_req & ~imem_ready.
- States: FETCH, HOLD, DISCARD.
- FETCH: imem_req=1, imem_addr=PCF.
  - ready & redir: data dropped; D gets bubble; PCF=target; stay FETCH.
  - ready & ~StallD & ~redir: D gets {rdata, PCF+4, 1}; PCF=PCF+4 (1 insn/cycle at zero wait).
  - ready & StallD: rdata and PCF+4 into skid buffer; PCF unchanged; go HOLD.
  - ~ready & redir: pend=target; D gets bubble; go DISCARD.
  - ~ready & ~StallD: D gets bubble.
- HOLD: imem_req=0.
  - StallD=1: stay.
  - StallD=0 & ~redir: D gets buffer contents; PCF=PCF+4; go FETCH.
  - StallD=0 & redir: buffer dropped; D gets bubble; PCF=target; go FETCH.
- DISCARD: imem_req=1 at old address (no abandon mid-handshake).
  - New redir overwrites pend (latest wins).
  - On ready: data dropped; PCF=pend, or the new target if redir is asserted that same cycle; go FETCH.
  - D gets bubbles whenever ~StallD.
- StallF: PCF holds regardless. The hazard unit drives StallF=StallD; behaviour with them unequal is undefined and not verified.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, HOLD, DISCARD}
  - NOP_INSTR=32'h0
  - WORD_ALIGN mask 32'hFFFF_FFFC
  - default RESET_PC
- Sub-module fetch_skid_buf: 64-bit instr+PC+4 holding register with load/clear.
- Next-PC mux stays inline.

Test Plan:
- Reset then zero-wait memory (ready always 1), RESET_PC=0: addrs 0,4,8 on successive cycles; InstrD valid from cycle 2; PCPlus4D 4,8,12.
- Two wait states per fetch: imem_addr stable 3 cycles per fetch; FetchWait=1 for 2 cycles; ValidD=0 bubbles between instructions.
- StallD=StallF=1 for 3 cycles, asserted in the cycle ready returns word 0x2002_0005 at PC 0x10:
  - enters HOLD, imem_req=0;
  - after release, InstrD=0x2002_0005, PCPlus4D=0x14, next addr 0x14.
- Redirect during DISCARD:
  - PCSrcD=1, PCBranchD=0x40 while fetch of 0x8 waiting;
  - then JumpD=1, PCJumpD=0x80 during DISCARD before ready;
  - result: data for 0x8 dropped, next request addr 0x80, no D write of 0x8.
- Redirect coincident with ready: JumpD=1, PCJumpD=0x103 with ready → D bubble; next imem_addr=0x100.
- Wrap and mid-fetch reset:
  - PCF=0xFFFF_FFFC with ready → next addr 0x0, PCPlus4D=0x0;
  - rst asserted during a wait-state fetch → next cycle ValidD=0, imem_req=0, and after release addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN       = 32'hFFFF_FFFC;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Holds one fetched word and its PC+4 while decode is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out
);

  logic [63:0] data_q;
  logic [63:0] data_d;

  // Clear wins over load so a redirect can never resurrect a dropped word.
  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = {NOP_INSTR, 32'h0000_0000};
    end else if (load) begin
      data_d = {instr_in, pc_plus4_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 64'h0;
    end else begin
      data_q <= data_d;
    end
  end

  assign instr_out    = data_q[63:32];
  assign pc_plus4_out = data_q[31:0];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : MIPS IF stage with IF/ID register, imem handshake and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchWait
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         redir;
  logic [31:0]  target;
  logic [31:0]  pcf_plus4;
  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc4;

  fetch_skid_buf u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (buf_load),
    .clear        (buf_clear),
    .instr_in     (imem_rdata),
    .pc_plus4_in  (pcf_plus4),
    .instr_out    (buf_instr),
    .pc_plus4_out (buf_pc4)
  );

  assign redir     = (PCSrcD | JumpD) & ~StallD;
  assign target    = align_word(JumpD ? PCJumpD : PCBranchD);
  assign pcf_plus4 = pcf_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    pend_d    = pend_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    // Any unstalled cycle writes a bubble unless a case below delivers a word.
    if (!StallD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redir) begin
            pcf_d = target;
          end else if (!StallD) begin
            instr_d = imem_rdata;
            pc4_d   = pcf_plus4;
            valid_d = 1'b1;
            pcf_d   = pcf_plus4;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (redir) begin
          pend_d  = target;
          state_d = DISCARD;
        end
      end

      HOLD: begin
        if (!StallD) begin
          if (redir) begin
            buf_clear = 1'b1;
            pcf_d     = target;
          end else begin
            instr_d = buf_instr;
            pc4_d   = buf_pc4;
            valid_d = 1'b1;
            pcf_d   = pcf_plus4;
          end
          state_d = FETCH;
        end
      end

      DISCARD: begin
        if (redir) begin
          pend_d = target;
        end
        // A stalled PC cannot take the pending target, so the stale request
        // is simply reissued and dropped again until the stall clears.
        if (imem_ready && !StallF) begin
          pcf_d   = redir ? target : pend_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (StallF) begin
      pcf_d = pcf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pcf_q   <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req  = ~rst & (state_q != HOLD);
  assign imem_addr = pcf_q;
  assign FetchWait = imem_req & ~imem_ready;
  assign InstrD    = instr_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomised scoreboard bench; expects the program-order stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CYCLES   = 3000;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, PCSrcD, JumpD, imem_ready;
  logic [31:0] PCBranchD, PCJumpD, imem_rdata, imem_addr, InstrD, PCPlus4D;
  logic        imem_req, ValidD, FetchWait;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchWait(FetchWait)
  );

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  logic [31:0] exp_q[$];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0: t = 32'h0000_0040;
      1: t = 32'h0000_0080;
      2: t = 32'h0000_0103;
      3: t = 32'hFFFF_FFF8;
      4: t = 32'hFFFF_FFFE;
      5: t = 32'h0000_0010;
      6: t = $urandom() & 32'h0000_FFFC;
      default: t = $urandom();
    endcase
    return t;
  endfunction

  // Inputs as seen by the DUT at the most recent rising edge.
  logic        p_rst = 1'b1;
  logic        p_stall = 1'b0, p_pcsrc = 1'b0, p_jump = 1'b0;
  logic        p_hs = 1'b0, p_wait = 1'b0;
  logic [31:0] p_br = '0, p_jt = '0;

  always @(posedge clk) begin
    p_rst   <= rst;
    p_stall <= StallD;
    p_pcsrc <= PCSrcD;
    p_jump  <= JumpD;
    p_br    <= PCBranchD;
    p_jt    <= PCJumpD;
    p_hs    <= imem_req & imem_ready;
    p_wait  <= imem_req & ~imem_ready;
  end

  logic [31:0] prev_instr = '0, prev_pc4 = '0, prev_addr = '0;
  logic        prev_valid = 1'b0;
  logic        discard_pend = 1'b0;
  logic        m_redir;
  logic [31:0] m_tgt, m_exp;

  always @(negedge clk) begin
    m_redir = (p_pcsrc | p_jump) & ~p_stall;
    m_tgt   = (p_jump ? p_jt : p_br) & 32'hFFFF_FFFC;

    if (rst) check(imem_req == 1'b0, "req_in_reset", {31'b0, imem_req}, 32'h0);
    check(FetchWait == (imem_req & ~imem_ready), "fetchwait", {31'b0, FetchWait},
          {31'b0, imem_req & ~imem_ready});
    if (imem_req) check(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & 32'hFFFF_FFFC);
    if (!ValidD) check(InstrD == 32'h0, "bubble_instr", InstrD, 32'h0);

    if (p_rst) begin
      check(ValidD == 1'b0, "rst_valid", {31'b0, ValidD}, 32'h0);
      check(InstrD == 32'h0, "rst_instr", InstrD, 32'h0);
      check(PCPlus4D == 32'h0, "rst_pc4", PCPlus4D, 32'h0);
      if (!rst) begin
        check(imem_req == 1'b1, "first_req", {31'b0, imem_req}, 32'h1);
        check(imem_addr == RESET_PC, "first_addr", imem_addr, RESET_PC);
      end
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      discard_pend = 1'b0;
    end else begin
      if (p_wait && !rst) begin
        check(imem_req == 1'b1, "req_held", {31'b0, imem_req}, 32'h1);
        check(imem_addr == prev_addr, "addr_stable", imem_addr, prev_addr);
      end
      if (p_stall) begin
        check(ValidD == prev_valid, "hold_valid", {31'b0, ValidD}, {31'b0, prev_valid});
        check(InstrD == prev_instr, "hold_instr", InstrD, prev_instr);
        check(PCPlus4D == prev_pc4, "hold_pc4", PCPlus4D, prev_pc4);
        if (p_hs && !discard_pend && !rst)
          check(imem_req == 1'b0, "skid_no_req", {31'b0, imem_req}, 32'h0);
      end else if (m_redir) begin
        check(ValidD == 1'b0, "redir_bubble", {31'b0, ValidD}, 32'h0);
        check(PCPlus4D == prev_pc4, "redir_pc4", PCPlus4D, prev_pc4);
        exp_q.delete();
        exp_q.push_back(m_tgt);
      end else if (ValidD) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_delivery", PCPlus4D, 32'h0);
        end else begin
          m_exp = exp_q.pop_front();
          check(PCPlus4D == m_exp + 32'd4, "deliver_pc4", PCPlus4D, m_exp + 32'd4);
          check(InstrD == mem_word(m_exp), "deliver_instr", InstrD, mem_word(m_exp));
          exp_q.push_back(m_exp + 32'd4);
          deliveries++;
        end
      end else begin
        check(PCPlus4D == prev_pc4, "bubble_pc4", PCPlus4D, prev_pc4);
      end
      if (m_redir && p_wait) discard_pend = 1'b1;
      else if (p_hs && !p_stall) discard_pend = 1'b0;
    end

    prev_instr = InstrD;
    prev_pc4   = PCPlus4D;
    prev_valid = ValidD;
    prev_addr  = imem_addr;
  end

  // Stimulus plus a variable-latency memory responder.
  initial begin
    int need, cnt, stall;
    need = 0;
    cnt  = 0;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b0;
    repeat (3) @(posedge clk);
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      rst   = (cyc >= 80) && ($urandom_range(0, 299) == 0);
      stall = ((cyc >= 80) && ($urandom_range(0, 4) == 0)) ? 1 : 0;
      StallD = stall[0];
      StallF = stall[0];
      PCSrcD = (cyc >= 80) && ($urandom_range(0, 9) == 0);
      JumpD  = (cyc >= 80) && ($urandom_range(0, 11) == 0);
      PCBranchD = pick_target();
      PCJumpD   = pick_target();
      #1;
      if (rst || !imem_req) begin
        imem_ready = 1'b0;
        if (rst) cnt = 0;
      end else if (cnt >= need) begin
        imem_ready = 1'b1;
        cnt = 0;
        need = (cyc < 30) ? 0 : (cyc < 80) ? 2 : $urandom_range(0, 3);
      end else begin
        imem_ready = 1'b0;
        cnt++;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; StallD = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check(deliveries >= 200, "liveness", deliveries, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
